// File: rtl/serial_pkg.sv
// Shared types and line levels for the framed serial transmitter.
// Also intended for reuse by a matching receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_byte_tx_if.sv
// Word-level valid/ready handshake into the serial transmitter.
// The master is upstream; the slave is the transmitter.
interface serial_byte_tx_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              lsb_first;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        output lsb_first,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  lsb_first,
        output data_ready
    );

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period counter: ticks on the last clock of every serial bit.
// pre_tick flags the clock before the tick so callers can register pulses.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE =
        (CLKS_PER_BIT > 1) ? CNT_W'(CLKS_PER_BIT - 2) : '0;
    localparam logic ONE_CLK = (CLKS_PER_BIT == 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick     = enable && (r_cnt == LAST);
    // With one clock per bit every clock is both tick and pre-tick
    assign pre_tick = ONE_CLK || (r_cnt == PRE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// Framed parallel-to-serial transmitter: start(0), DATA_W bits, stop(1).
// Bit order chosen per word; all line-side outputs are registered.
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    serial_byte_tx_if.slave  s_if,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic ONE_CLK = (CLKS_PER_BIT == 1);

    tx_state_e         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic              r_lsb;
    logic [BIT_W-1:0]  r_bitcnt;
    logic              r_ser;
    logic              r_busy;
    logic              r_done;

    logic w_accept;
    logic w_tick;
    logic w_pre_tick;
    logic w_last_bit;
    logic w_first_bit;
    logic w_next_bit;

    assign s_if.data_ready = (r_state == IDLE);
    assign w_accept    = s_if.data_valid && s_if.data_ready;
    assign w_last_bit  = (r_bitcnt == LAST_BIT);
    assign w_first_bit = r_lsb ? r_shreg[0] : r_shreg[DATA_W-1];
    // Bit that will be on the line after this shift
    assign w_next_bit  = r_lsb ? r_shreg[1] : r_shreg[DATA_W-2];

    assign ser_out = r_ser;
    assign busy    = r_busy;
    assign done    = r_done;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (w_accept),
        .enable   (r_state != IDLE),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_lsb    <= 1'b0;
            r_bitcnt <= '0;
            r_ser    <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg  <= s_if.data_in;
                        r_lsb    <= s_if.lsb_first;
                        r_bitcnt <= '0;
                        r_state  <= START;
                        r_ser    <= START_LEVEL;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_ser   <= w_first_bit;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shreg <= r_lsb ? (r_shreg >> 1)
                                         : (r_shreg << 1);
                        if (w_last_bit) begin
                            r_state <= STOP;
                            r_ser   <= IDLE_LEVEL;
                            r_done  <= ONE_CLK;
                        end else begin
                            r_bitcnt <= r_bitcnt + BIT_W'(1);
                            r_ser    <= w_next_bit;
                        end
                    end
                end
                STOP: begin
                    // done lands on the final STOP clock
                    if (!ONE_CLK && w_pre_tick) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
